// File: rtl/psk_pkg.sv
// Shared definitions for the PSK loopback frame path: frame FSM states,
// default framing constants and the PRBS-9 tap positions.
package psk_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

  localparam int         DEFAULT_FRAME_LEN = 64;
  localparam logic [8:0] DEFAULT_PRBS_SEED = 9'h1FF;

  // x^9 + x^5 + 1: feedback taps on state bits 8 and 4
  localparam int PRBS_TAP_HI = 8;
  localparam int PRBS_TAP_LO = 4;

endpackage

// File: rtl/prbs9_byte.sv
// Combinational 8-step PRBS-9 advance; the first generated bit lands in bit 7.
// Shared by the Tx frame source and the Rx frame checker.
module prbs9_byte
  import psk_pkg::*;
(
  input  logic [8:0] state_in,
  output logic [8:0] state_out,
  output logic [7:0] byte_out
);

  always_comb begin
    logic [8:0] s;
    logic       fb;
    s        = state_in;
    fb       = 1'b0;
    byte_out = '0;
    for (int i = 0; i < 8; i++) begin
      fb            = s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
      byte_out[7-i] = fb;
      s             = {s[7:0], fb};
    end
    state_out = s;
  end

endmodule

// File: rtl/rx_frame_checker.sv
// Rx frame checker: regenerates the PRBS-9 payload per frame, validates frame
// length and keeps saturating frame / frame-error / bit-error statistics.
module rx_frame_checker
  import psk_pkg::*;
#(
  parameter int         FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int         CNT_W     = 16,
  parameter logic [8:0] PRBS_SEED = DEFAULT_PRBS_SEED
)(
  input  logic             clk_32M768,
  input  logic             rst_n_32M768,
  input  logic             clr,
  input  logic [7:0]       data_tdata,
  input  logic             data_tvalid,
  input  logic             data_tlast,
  input  logic             data_tuser,
  output logic             locked,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);

  localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [7:0]       FULL_IDX = 8'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == CNT_MAX) ? a : a + 1'b1;
  endfunction

  frame_state_t     state, state_next;
  logic [7:0]       idx, idx_next;
  logic [8:0]       lfsr, lfsr_next;
  logic [CNT_W-1:0] acc, acc_next, acc_beat;
  logic [8:0]       prbs_in, prbs_next;
  logic [7:0]       prbs_byte, diff;
  logic [3:0]       pop;
  logic [CNT_W-1:0] errs;
  logic             close, close_ok;
  logic [CNT_W-1:0] close_acc;

  // A tuser beat is always compared against the sequence restarted from the seed
  assign prbs_in = data_tuser ? PRBS_SEED : lfsr;

  prbs9_byte u_prbs (
    .state_in  (prbs_in),
    .state_out (prbs_next),
    .byte_out  (prbs_byte)
  );

  assign diff = data_tdata ^ prbs_byte;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) pop = pop + {3'b000, diff[i]};
  end

  assign errs     = CNT_W'(pop);
  assign acc_beat = sat_add(acc, errs);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    lfsr_next  = lfsr;
    acc_next   = acc;
    close      = 1'b0;
    close_ok   = 1'b0;
    close_acc  = acc;
    if (data_tvalid) begin
      unique case (state)
        IDLE: begin
          if (data_tuser) begin
            lfsr_next = prbs_next;
            if (data_tlast) begin
              close     = 1'b1;
              close_acc = errs;
              acc_next  = '0;
              idx_next  = '0;
            end else begin
              state_next = IN_FRAME;
              idx_next   = 8'd1;
              acc_next   = errs;
            end
          end
        end
        IN_FRAME: begin
          if (data_tuser) begin
            // Restart on this beat; a restart that also carries tlast is a
            // 1-byte frame that cannot get its own close and is dropped.
            close      = 1'b1;
            close_acc  = acc;
            lfsr_next  = prbs_next;
            idx_next   = data_tlast ? 8'd0 : 8'd1;
            acc_next   = data_tlast ? '0 : errs;
            state_next = data_tlast ? IDLE : IN_FRAME;
          end else if (data_tlast) begin
            close      = 1'b1;
            close_ok   = (idx == LAST_IDX) && (acc_beat == '0);
            close_acc  = acc_beat;
            lfsr_next  = prbs_next;
            idx_next   = '0;
            acc_next   = '0;
            state_next = IDLE;
          end else if (idx == FULL_IDX) begin
            close      = 1'b1;
            close_acc  = acc;
            idx_next   = '0;
            acc_next   = '0;
            state_next = IDLE;
          end else begin
            acc_next  = acc_beat;
            idx_next  = idx + 8'd1;
            lfsr_next = prbs_next;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_32M768) begin
    if (!rst_n_32M768) begin
      state         <= IDLE;
      idx           <= '0;
      lfsr          <= PRBS_SEED;
      acc           <= '0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      frame_cnt     <= '0;
      frame_err_cnt <= '0;
      bit_err_cnt   <= '0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      lfsr       <= lfsr_next;
      acc        <= clr ? '0 : acc_next;
      frame_done <= close;
      frame_ok   <= close && close_ok;
      // clr outranks a coincident close; the pulse still goes out
      if (clr) begin
        frame_cnt     <= '0;
        frame_err_cnt <= '0;
        bit_err_cnt   <= '0;
      end else if (close) begin
        frame_cnt <= sat_inc(frame_cnt);
        if (!close_ok) frame_err_cnt <= sat_inc(frame_err_cnt);
        bit_err_cnt <= sat_add(bit_err_cnt, close_acc);
      end
    end
  end

  assign locked = (state == IN_FRAME);

endmodule

// File: doc/rx_frame_checker.md
# rx_frame_checker

Receive-side frame checker that sits directly after the `Rx` byte-stream output (`data_tdata`/`data_tvalid`/`data_tlast`/`data_tuser`) in the loopback and on-board BER path. It consumes the byte stream the transmitter frames, regenerates the expected PRBS-9 payload locally, and keeps frame, frame-error and bit-error statistics. It is the reader counterpart of the Tx frame source, so loopback runs can be judged in hardware instead of by CSV post-processing.

## Interface
- `FRAME_LEN`, 64: payload bytes per frame; legal range 2..255.
- `CNT_W`, 16: width of every statistics counter.
- `PRBS_SEED`, 9'h1FF: LFSR value loaded at each frame start; must be nonzero.
- `clk_32M768`  in  1  system clock.
- `rst_n_32M768`  in  1  synchronous, active-low reset.
- `clr`  in  1  synchronous clear of all statistics; FSM unaffected.
- `data_tdata`  in  8  received byte.
- `data_tvalid`  in  1  byte strobe. There is no back-pressure and no ready signal; every valid beat is consumed.
- `data_tlast`  in  1  last byte of frame; qualified by `data_tvalid`.
- `data_tuser`  in  1  first byte of frame; qualified by `data_tvalid`.
- `locked`  out  1  high while inside a frame (state `IN_FRAME`).
- `frame_done`  out  1  one-cycle pulse when a frame closes, good or bad.
- `frame_ok`  out  1  valid with `frame_done`: 1 when the frame had correct length and zero bit errors.
- `frame_cnt`  out  CNT_W  frames closed, saturating.
- `frame_err_cnt`  out  CNT_W  frames closed with `frame_ok`=0, saturating.
- `bit_err_cnt`  out  CNT_W  payload bit errors, saturating.

## Operation
- **Expected data:** PRBS-9 with polynomial x^9+x^5+1. Per step, b = s[8]^s[4], then s <= {s[7:0], b}. One byte is 8 steps; the first bit produced lands in bit 7. The LFSR is loaded with `PRBS_SEED` on every `tuser` beat, and byte 0 is compared against the first 8 steps from the seed.
- **Per-beat check:** errors = popcount(`data_tdata` ^ expected), range 0..8. These are summed into a per-frame accumulator `acc` (width CNT_W, saturating).
- **FSM states:**
  - `IDLE`: hunt for a frame start.
    - A valid beat with `tuser`=1 goes to `IN_FRAME`, sets byte index `idx`=1 and checks byte 0.
    - A valid beat with `tuser`=0 is ignored.
    - A valid beat with both `tuser` and `tlast` set is a 1-byte frame. It closes immediately as a length error and the FSM stays in `IDLE`.
  - `IN_FRAME`: check each valid beat and increment `idx`.
    - `tlast` with `idx`==FRAME_LEN-1 closes the frame with length OK, then goes to `IDLE`.
    - `tlast` at any other index closes the frame as a length error, then goes to `IDLE`.
    - `tuser` mid-frame closes the current frame as a length error in the same cycle. That beat starts a new frame: LFSR reseeded, byte checked as byte 0, `idx`=1, FSM stays in `IN_FRAME`.
    - `idx` reaching FRAME_LEN with no `tlast`, and that beat not carrying `tuser`, closes the frame as a length error. The FSM goes to `IDLE` and that beat is not checked.
- **Frame close:**
  - `frame_cnt` increments.
  - `frame_ok` = length OK && `acc` (including the closing byte) == 0.
  - `frame_err_cnt` increments when `frame_ok`=0.
  - `bit_err_cnt` adds `acc` (saturating).
  - `acc` clears.
- **`clr`:** zeroes the three counters and `acc`. If `clr` and a close happen in the same cycle, `clr` wins: counters read 0 next cycle, but `frame_done`/`frame_ok` still pulse.
- **Reset mid-frame:** the partial frame is discarded with no count. The FSM returns to `IDLE`.

## Timing
- Reset values:
  - `locked`=0, `frame_done`=0, `frame_ok`=0.
  - All counters 0, `acc`=0, `idx`=0.
  - LFSR=`PRBS_SEED`, state `IDLE`.
- All outputs are registered.
- `frame_done`, `frame_ok` and the counter updates appear one cycle after the closing beat.
- `locked` rises the cycle after the `tuser` beat. It falls the cycle after the closing beat, unless that beat also starts a new frame.
- Back-to-back valid beats on consecutive cycles are supported, including a `tlast` beat immediately followed by the next `tuser` beat.
- `tuser`/`tlast` are ignored when `tvalid`=0.
- Saturation: each counter holds at 2^CNT_W-1.

## Structure
- Shared package `psk_pkg`:
  - FSM state enum (`IDLE`, `IN_FRAME`).
  - Default constants `FRAME_LEN`, `PRBS_SEED`.
  - PRBS-9 tap positions.
- Sub-module `prbs9_byte`: combinational 8-step LFSR advance (state in → next state and expected byte out). The same module is reused by the Tx frame source.
- The 8-bit popcount stays inline.

## Test plan
- **Clean frames:** 3 frames of 64 correct PRBS bytes, back-to-back → 3 `frame_done` pulses, each with `frame_ok`=1; `frame_cnt`=3, `frame_err_cnt`=0, `bit_err_cnt`=0.
- **Bit errors:** byte 5 XOR 8'h81 and byte 40 XOR 8'hFF → `frame_ok`=0, `bit_err_cnt`=10, `frame_err_cnt`=1.
- **Early tuser:** `tuser` at byte 20, followed by a full clean frame → 2 closes; first `frame_ok`=0, second `frame_ok`=1; `frame_err_cnt`=1; `locked` stays high.
- **Length errors:**
  - `tlast` at byte 30 → length error, `bit_err_cnt` unchanged.
  - 70 bytes with no `tlast` → close after byte 63, bytes 64..69 ignored, `frame_err_cnt` +1.
- **Reset and clear:**
  - `rst_n_32M768` low for 1 cycle mid-frame → no `frame_done`; outputs at reset values next cycle.
  - `clr` coincident with a close → `frame_done` pulses and counters read 0.
- **Saturation (CNT_W=4):** 20 all-0xFF frames → `bit_err_cnt`=15, `frame_cnt`=15, `frame_err_cnt`=15.
